// File: rtl/pac_fetch_pkg.sv
// Shared types for the PC fetch path: FSM states, buffered fetch entry, and
// the word-alignment helper.
package pac_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of {pc, instr} pairs; flush empties it at the edge.
module fetch_fifo
  import pac_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot the same cycle, so push-on-full with pop is legal
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wp] <= wdata;
    end
  end

endmodule

// File: rtl/pc_fetch_reader.sv
// Samples the PC, fetches the instruction over a req/ack memory port and
// buffers {pc, instr} pairs for decode; supports flush and sticky faults.
module pc_fetch_reader
  import pac_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inputPC,
  input  logic        pcValid,
  input  logic        flush,
  output logic [31:0] memAddr,
  output logic        memReq,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic [31:0] instrOut,
  output logic [31:0] instrPC,
  output logic        instrValid,
  input  logic        instrReady,
  output logic        pcTaken,
  output logic        fetchFault,
  output logic [31:0] lastPC
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  fetch_state_t  state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          accept, push, fault_set, room;
  logic [CW-1:0] count;
  logic          full, empty;
  fetch_entry_t  head;

  assign memReq = (state == REQ);
  // the in-flight fetch already owns a slot, so it counts against capacity
  assign room   = !full && ((count + CW'(memReq)) < CW'(DEPTH));

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    accept    = 1'b0;
    push      = 1'b0;
    fault_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (pcValid && !flush) begin
          if (!is_aligned(inputPC)) begin
            state_nxt = FAULT;
            fault_set = 1'b1;
          end else if (room) begin
            state_nxt = REQ;
            accept    = 1'b1;
          end
        end
      end
      REQ: begin
        if (flush) begin
          state_nxt = IDLE;
          tcnt_nxt  = '0;
        end else if (memAck) begin
          push      = 1'b1;
          state_nxt = IDLE;
          tcnt_nxt  = '0;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_nxt = FAULT;
          fault_set = 1'b1;
          tcnt_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      FAULT: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      memAddr    <= '0;
      lastPC     <= RESET_PC;
      pcTaken    <= 1'b0;
      fetchFault <= 1'b0;
    end else begin
      state   <= state_nxt;
      tcnt    <= tcnt_nxt;
      pcTaken <= accept;
      if (accept) begin
        memAddr <= inputPC;
        lastPC  <= inputPC;
      end
      if (fault_set) fetchFault <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ('{pc: memAddr, instr: memData}),
    .pop   (instrValid && instrReady),
    .flush (flush),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign instrValid = !empty;
  assign instrOut   = head.instr;
  assign instrPC    = head.pc;

endmodule

// File: tb/tb_pc_fetch_reader.sv
// Directed scenarios plus a randomized run against a queue-based fetch model.
module tb_pc_fetch_reader;

  localparam int          DEPTH    = 2;
  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, pcValid, flush, memAck, instrReady;
  logic [31:0] inputPC, memData;
  logic [31:0] memAddr, instrOut, instrPC, lastPC;
  logic        memReq, instrValid, pcTaken, fetchFault;

  int vectors = 0;
  int miscompares = 0;

  pc_fetch_reader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .inputPC(inputPC), .pcValid(pcValid), .flush(flush),
    .memAddr(memAddr), .memReq(memReq), .memAck(memAck), .memData(memData),
    .instrOut(instrOut), .instrPC(instrPC), .instrValid(instrValid),
    .instrReady(instrReady), .pcTaken(pcTaken), .fetchFault(fetchFault),
    .lastPC(lastPC)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a queue of fetched pairs plus an outstanding-fetch flag.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  bit          m_busy, m_fault, m_taken;
  int          m_cnt;
  logic [31:0] m_addr, m_last;

  task automatic model_step();
    int sz = mq.size();
    m_taken = 0;
    if (rst) begin
      mq.delete(); m_busy = 0; m_fault = 0; m_cnt = 0; m_addr = 0; m_last = RESET_PC;
      return;
    end
    if (flush) begin
      mq.delete(); m_busy = 0; m_cnt = 0;
      return;
    end
    if (sz > 0 && instrReady) void'(mq.pop_front());
    if (m_fault) begin
    end else if (m_busy) begin
      if (memAck) begin
        mq.push_back('{pc: m_addr, instr: memData});
        m_busy = 0; m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == TIMEOUT) begin m_busy = 0; m_fault = 1; m_cnt = 0; end
      end
    end else if (pcValid) begin
      if (inputPC % 4 != 0) m_fault = 1;
      else if (sz < DEPTH) begin
        m_busy = 1; m_addr = inputPC; m_last = inputPC; m_taken = 1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
    pcValid = 1; inputPC = pc; cycle(); pcValid = 0;
    memAck = 1; memData = data; cycle(); memAck = 0;
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; cycle(); cycle(); rst = 0;
    vectors++; if (memReq !== 1'b0) begin miscompares++; $display("FAIL reset_memReq got %0h want 0", memReq); end
    vectors++; if (memAddr !== 32'd0) begin miscompares++; $display("FAIL reset_memAddr got %0h want 0", memAddr); end
    vectors++; if (instrValid !== 1'b0) begin miscompares++; $display("FAIL reset_instrValid got %0h want 0", instrValid); end
    vectors++; if (instrOut !== 32'd0 || instrPC !== 32'd0) begin miscompares++; $display("FAIL reset_head got %0h/%0h want 0/0", instrOut, instrPC); end
    vectors++; if (pcTaken !== 1'b0 || fetchFault !== 1'b0) begin miscompares++; $display("FAIL reset_flags got %0h/%0h want 0/0", pcTaken, fetchFault); end
    vectors++; if (lastPC !== RESET_PC) begin miscompares++; $display("FAIL reset_lastPC got %0h want %0h", lastPC, RESET_PC); end
  endtask

  task automatic test_single();
    pcValid = 1; inputPC = 32'd56; cycle(); pcValid = 0;
    vectors++; if (pcTaken !== 1'b1) begin miscompares++; $display("FAIL single_pcTaken got %0h want 1", pcTaken); end
    vectors++; if (memReq !== 1'b1 || memAddr !== 32'd56) begin miscompares++; $display("FAIL single_req got %0h@%0d want 1@56", memReq, memAddr); end
    vectors++; if (lastPC !== 32'd56) begin miscompares++; $display("FAIL single_lastPC got %0d want 56", lastPC); end
    memAck = 1; memData = 32'hE3A00001; cycle(); memAck = 0;
    vectors++; if (instrValid !== 1'b1 || instrOut !== 32'hE3A00001 || instrPC !== 32'd56) begin
      miscompares++; $display("FAIL single_out got v=%0h %0h@%0d want v=1 e3a00001@56", instrValid, instrOut, instrPC); end
    vectors++; if (memReq !== 1'b0 || pcTaken !== 1'b0) begin miscompares++; $display("FAIL single_done got req=%0h taken=%0h want 0/0", memReq, pcTaken); end
    instrReady = 1; cycle(); instrReady = 0;
    vectors++; if (instrValid !== 1'b0) begin miscompares++; $display("FAIL single_pop got %0h want 0", instrValid); end
  endtask

  task automatic test_fifo_full();
    instrReady = 0;
    do_fetch(32'd0, 32'h1000_0000);
    do_fetch(32'd4, 32'h1000_0004);
    pcValid = 1; inputPC = 32'd8;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++; if (pcTaken !== 1'b0 || memReq !== 1'b0) begin miscompares++; $display("FAIL full_blocked got taken=%0h req=%0h want 0/0", pcTaken, memReq); end
    end
    vectors++; if (instrPC !== 32'd0 || instrOut !== 32'h1000_0000) begin miscompares++; $display("FAIL full_hold got %0h@%0d want 10000000@0", instrOut, instrPC); end
    instrReady = 1; cycle(); instrReady = 0;
    vectors++; if (instrPC !== 32'd4 || pcTaken !== 1'b0) begin miscompares++; $display("FAIL full_pop1 got pc=%0d taken=%0h want 4/0", instrPC, pcTaken); end
    cycle(); pcValid = 0;
    vectors++; if (pcTaken !== 1'b1 || memAddr !== 32'd8) begin miscompares++; $display("FAIL full_accept8 got taken=%0h addr=%0d want 1/8", pcTaken, memAddr); end
    memAck = 1; memData = 32'h1000_0008; cycle(); memAck = 0;
    instrReady = 1;
    vectors++; if (instrPC !== 32'd4) begin miscompares++; $display("FAIL full_order4 got %0d want 4", instrPC); end
    cycle();
    vectors++; if (instrPC !== 32'd8 || instrOut !== 32'h1000_0008) begin miscompares++; $display("FAIL full_order8 got %0h@%0d want 10000008@8", instrOut, instrPC); end
    cycle(); instrReady = 0;
    vectors++; if (instrValid !== 1'b0) begin miscompares++; $display("FAIL full_drained got %0h want 0", instrValid); end
  endtask

  task automatic test_flush();
    instrReady = 0;
    do_fetch(32'd0, 32'h2222_0000);
    pcValid = 1; inputPC = 32'd79 & ~32'd3; cycle(); pcValid = 0;
    vectors++; if (memReq !== 1'b1 || memAddr !== 32'd76) begin miscompares++; $display("FAIL flush_req got %0h@%0d want 1@76", memReq, memAddr); end
    memAck = 1; flush = 1; memData = 32'hDEAD_BEEF; pcValid = 1; inputPC = 32'd12;
    cycle(); memAck = 0; flush = 0; pcValid = 0;
    vectors++; if (instrValid !== 1'b0 || memReq !== 1'b0 || pcTaken !== 1'b0) begin
      miscompares++; $display("FAIL flush_drop got v=%0h req=%0h taken=%0h want 0/0/0", instrValid, memReq, pcTaken); end
    pcValid = 1; inputPC = 32'd896; cycle(); pcValid = 0;
    vectors++; if (pcTaken !== 1'b1 || memAddr !== 32'd896) begin miscompares++; $display("FAIL flush_next got taken=%0h addr=%0d want 1/896", pcTaken, memAddr); end
    memAck = 1; memData = 32'h0896_0896; cycle(); memAck = 0;
    vectors++; if (instrValid !== 1'b1 || instrPC !== 32'd896 || instrOut !== 32'h0896_0896) begin
      miscompares++; $display("FAIL flush_after got v=%0h %0h@%0d want 1 08960896@896", instrValid, instrOut, instrPC); end
    instrReady = 1; cycle(); instrReady = 0;
  endtask

  task automatic test_misaligned();
    pcValid = 1; inputPC = 32'd23; cycle(); pcValid = 0;
    vectors++; if (memReq !== 1'b0 || pcTaken !== 1'b0 || fetchFault !== 1'b1) begin
      miscompares++; $display("FAIL misal_fault got req=%0h taken=%0h fault=%0h want 0/0/1", memReq, pcTaken, fetchFault); end
    pcValid = 1; inputPC = 32'd64; cycle(); cycle(); pcValid = 0;
    vectors++; if (memReq !== 1'b0 || pcTaken !== 1'b0 || fetchFault !== 1'b1 || lastPC !== 32'd896) begin
      miscompares++; $display("FAIL misal_sticky got req=%0h taken=%0h fault=%0h last=%0d want 0/0/1/896", memReq, pcTaken, fetchFault, lastPC); end
    do_reset();
    vectors++; if (fetchFault !== 1'b0 || lastPC !== RESET_PC) begin miscompares++; $display("FAIL misal_clear got fault=%0h last=%0h want 0/%0h", fetchFault, lastPC, RESET_PC); end
  endtask

  task automatic test_timeout();
    int n = 0;
    instrReady = 0;
    do_fetch(32'd300, 32'hCAFE_0300);
    pcValid = 1; inputPC = 32'd200; cycle(); pcValid = 0;
    while (memReq === 1'b1 && n < 40) begin n++; cycle(); end
    vectors++; if (n !== TIMEOUT) begin miscompares++; $display("FAIL timeout_cycles got %0d want %0d", n, TIMEOUT); end
    vectors++; if (fetchFault !== 1'b1) begin miscompares++; $display("FAIL timeout_fault got %0h want 1", fetchFault); end
    pcValid = 1; inputPC = 32'd400; instrReady = 1;
    vectors++; if (instrValid !== 1'b1 || instrPC !== 32'd300 || instrOut !== 32'hCAFE_0300) begin
      miscompares++; $display("FAIL timeout_drain got v=%0h %0h@%0d want 1 cafe0300@300", instrValid, instrOut, instrPC); end
    cycle(); pcValid = 0; instrReady = 0;
    vectors++; if (instrValid !== 1'b0 || memReq !== 1'b0 || pcTaken !== 1'b0) begin
      miscompares++; $display("FAIL timeout_after got v=%0h req=%0h taken=%0h want 0/0/0", instrValid, memReq, pcTaken); end
    do_reset();
  endtask

  task automatic test_reset_midreq();
    pcValid = 1; inputPC = 32'd44; cycle(); pcValid = 0;
    vectors++; if (memReq !== 1'b1) begin miscompares++; $display("FAIL rstreq_req got %0h want 1", memReq); end
    do_reset();
    vectors++; if (memReq !== 1'b0 || memAddr !== 32'd0 || lastPC !== RESET_PC || pcTaken !== 1'b0 || instrValid !== 1'b0) begin
      miscompares++; $display("FAIL rstreq_state got req=%0h addr=%0h last=%0h taken=%0h v=%0h want 0/0/%0h/0/0", memReq, memAddr, lastPC, pcTaken, instrValid, RESET_PC); end
    memAck = 1; memData = 32'h5555_AAAA; cycle(); memAck = 0; cycle();
    vectors++; if (instrValid !== 1'b0) begin miscompares++; $display("FAIL rstreq_lateack got %0h want 0", instrValid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pcValid    = 1'($urandom_range(0, 1));
      inputPC    = 32'($urandom_range(0, 1023)) << 2;
      flush      = ($urandom_range(0, 15) == 0);
      memAck     = ($urandom_range(0, 2) != 0);
      memData    = $urandom;
      instrReady = 1'($urandom_range(0, 1));
      cycle();
      vectors++; if (memReq !== m_busy || memAddr !== m_addr) begin miscompares++; $display("FAIL rand_req[%0d] got %0h@%0h want %0h@%0h", i, memReq, memAddr, m_busy, m_addr); end
      vectors++; if (pcTaken !== m_taken || lastPC !== m_last || fetchFault !== m_fault) begin
        miscompares++; $display("FAIL rand_pc[%0d] got taken=%0h last=%0h fault=%0h want %0h/%0h/%0h", i, pcTaken, lastPC, fetchFault, m_taken, m_last, m_fault); end
      vectors++; if (instrValid !== (mq.size() > 0)) begin miscompares++; $display("FAIL rand_valid[%0d] got %0h want %0h", i, instrValid, mq.size() > 0); end
      if (mq.size() > 0) begin
        vectors++; if (instrPC !== mq[0].pc || instrOut !== mq[0].instr) begin
          miscompares++; $display("FAIL rand_head[%0d] got %0h@%0h want %0h@%0h", i, instrOut, instrPC, mq[0].instr, mq[0].pc); end
      end
    end
    flush = 0; memAck = 0; pcValid = 0; instrReady = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; pcValid = 0; flush = 0; memAck = 0; instrReady = 0;
    inputPC = '0; memData = '0;
    test_reset();
    test_single();
    test_fifo_full();
    test_flush();
    test_misaligned();
    test_timeout();
    test_reset_midreq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
